// File: rtl/cdu_pkg.sv
// Shared definitions for the CDU coarse resolver loop: sequencer states,
// DC switch bit positions and the octant-to-switch-pair table.
package cdu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGapA,
        StDriveA,
        StGapB,
        StDriveB,
        StResolve
    } state_e;

    // Bit positions in the dc vector; DCn lives at bit n-1.
    localparam int unsigned DC1  = 0;
    localparam int unsigned DC2  = 1;
    localparam int unsigned DC3  = 2;
    localparam int unsigned DC4  = 3;
    localparam int unsigned DC5  = 4;
    localparam int unsigned DC6  = 5;
    localparam int unsigned DC7  = 6;
    localparam int unsigned DC8  = 7;
    localparam int unsigned DC9  = 8;
    localparam int unsigned DC10 = 9;
    localparam int unsigned DC11 = 10;
    localparam int unsigned DC12 = 11;

    typedef struct packed {
        logic [3:0] sin_bit;
        logic [3:0] cos_bit;
    } sw_pair_t;

    localparam sw_pair_t OCT_TABLE [8] = '{
        '{sin_bit: 4'(DC3), cos_bit: 4'(DC5)},
        '{sin_bit: 4'(DC4), cos_bit: 4'(DC6)},
        '{sin_bit: 4'(DC2), cos_bit: 4'(DC6)},
        '{sin_bit: 4'(DC1), cos_bit: 4'(DC5)},
        '{sin_bit: 4'(DC1), cos_bit: 4'(DC7)},
        '{sin_bit: 4'(DC2), cos_bit: 4'(DC8)},
        '{sin_bit: 4'(DC4), cos_bit: 4'(DC8)},
        '{sin_bit: 4'(DC3), cos_bit: 4'(DC7)}
    };

endpackage

// File: rtl/coarse_decode.sv
// Combinational decode of octant, reference bits and test phase into the
// twelve coarse summing-network switch enables.
module coarse_decode
    import cdu_pkg::*;
(
    input  logic [2:0]  oct,
    input  logic [3:0]  res,
    input  logic        phase,
    output logic [11:0] pattern
);

    logic [2:0] sin_oct;

    // Phase B borrows the sine switch from the opposite half-turn octant.
    assign sin_oct = phase ? (oct ^ 3'b100) : oct;

    always_comb begin
        pattern = '0;
        pattern[OCT_TABLE[sin_oct].sin_bit] = 1'b1;
        pattern[OCT_TABLE[oct].cos_bit]     = 1'b1;
        pattern[DC9]  = res[3];
        pattern[DC10] = res[2];
        pattern[DC11] = res[1];
        pattern[DC12] = res[0];
    end

endmodule

// File: rtl/coarse_seq.sv
// Coarse error-loop sequencer: snapshots the angle, drives two switch test
// phases, samples the Schmitt trigger and issues count requests / error flag.
module coarse_seq
    import cdu_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned ERR_CNT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] angle,
    input  logic        sample_strb,
    input  logic        tlc1h,
    output logic [11:0] dc,
    output logic        cnt_up,
    output logic        cnt_dn,
    output logic        coarse_err,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [2:0]  oct_q, oct_d;
    logic [3:0]  res_q, res_d;
    logic [7:0]  settle_q, settle_d;
    logic        a_hit_q, a_hit_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic [11:0] dc_q, dc_d;
    logic        cnt_up_q, cnt_up_d;
    logic        cnt_dn_q, cnt_dn_d;
    logic        coarse_err_q, coarse_err_d;
    logic        busy_q, busy_d;
    logic [11:0] pattern;
    logic        fault;

    coarse_decode u_decode (
        .oct     (oct_q),
        .res     (res_q),
        .phase   (state_d == StDriveB),
        .pattern (pattern)
    );

    always_comb begin
        state_d      = state_q;
        oct_d        = oct_q;
        res_d        = res_q;
        settle_d     = settle_q;
        a_hit_d      = a_hit_q;
        err_cnt_d    = err_cnt_q;
        coarse_err_d = coarse_err_q;
        cnt_up_d     = 1'b0;
        cnt_dn_d     = 1'b0;
        fault        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StGapA;
                    oct_d   = angle[15:13];
                    res_d   = angle[12:9];
                end
            end
            StGapA: begin
                state_d  = StDriveA;
                settle_d = 8'(SETTLE_CYC);
            end
            StDriveA: begin
                if (settle_q != 8'd0) begin
                    settle_d = settle_q - 8'd1;
                end else if (sample_strb) begin
                    a_hit_d = tlc1h;
                    state_d = StGapB;
                end
            end
            StGapB: begin
                state_d  = StDriveB;
                settle_d = 8'(SETTLE_CYC);
            end
            StDriveB: begin
                if (settle_q != 8'd0) begin
                    settle_d = settle_q - 8'd1;
                end else if (sample_strb) begin
                    // B result is used straight from tlc1h so the pulse and the
                    // error flag land on the edge that enters RESOLVE.
                    state_d  = StResolve;
                    cnt_up_d = a_hit_q & ~tlc1h;
                    cnt_dn_d = ~a_hit_q & tlc1h;
                    fault    = a_hit_q & tlc1h;
                    if (a_hit_q | tlc1h) begin
                        err_cnt_d = (err_cnt_q == 4'hF) ? 4'hF : err_cnt_q + 4'd1;
                    end else begin
                        err_cnt_d = 4'd0;
                    end
                    coarse_err_d = (32'(err_cnt_d) >= ERR_CNT) | fault;
                end
            end
            StResolve: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        dc_d   = ((state_d == StDriveA) || (state_d == StDriveB)) ? pattern : 12'd0;
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            oct_q        <= 3'd0;
            res_q        <= 4'd0;
            settle_q     <= 8'd0;
            a_hit_q      <= 1'b0;
            err_cnt_q    <= 4'd0;
            dc_q         <= 12'd0;
            cnt_up_q     <= 1'b0;
            cnt_dn_q     <= 1'b0;
            coarse_err_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            oct_q        <= oct_d;
            res_q        <= res_d;
            settle_q     <= settle_d;
            a_hit_q      <= a_hit_d;
            err_cnt_q    <= err_cnt_d;
            dc_q         <= dc_d;
            cnt_up_q     <= cnt_up_d;
            cnt_dn_q     <= cnt_dn_d;
            coarse_err_q <= coarse_err_d;
            busy_q       <= busy_d;
        end
    end

    assign dc         = dc_q;
    assign cnt_up     = cnt_up_q;
    assign cnt_dn     = cnt_dn_q;
    assign coarse_err = coarse_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_coarse_seq.sv
// Self-checking bench for coarse_seq: scoreboarded measurement cycles plus
// reset, settling and back-to-back scenarios.
module tb_coarse_seq;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned ERRN   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] angle;
    logic        sample_strb;
    logic        tlc1h;
    logic [11:0] dc;
    logic        cnt_up;
    logic        cnt_dn;
    logic        coarse_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] dc_a;
        logic [11:0] dc_b;
        int          up;
        int          dn;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   err_cnt_m = 0;

    // Spec table, written as DC numbers (1-based).
    int sin_tab [8] = '{3, 4, 2, 1, 1, 2, 4, 3};
    int cos_tab [8] = '{5, 6, 6, 5, 7, 8, 8, 7};

    coarse_seq #(
        .SETTLE_CYC (SETTLE),
        .ERR_CNT    (ERRN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .angle       (angle),
        .sample_strb (sample_strb),
        .tlc1h       (tlc1h),
        .dc          (dc),
        .cnt_up      (cnt_up),
        .cnt_dn      (cnt_dn),
        .coarse_err  (coarse_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] model_dc(input logic [2:0] o, input logic [3:0] r,
                                             input bit phase_b);
        logic [11:0] v;
        logic [2:0]  so;
        so = phase_b ? (o ^ 3'd4) : o;
        v = 12'd0;
        v[sin_tab[so] - 1] = 1'b1;
        v[cos_tab[o] - 1]  = 1'b1;
        v[8]  = r[3];
        v[9]  = r[2];
        v[10] = r[1];
        v[11] = r[0];
        return v;
    endfunction

    // Runs one full measurement cycle from IDLE; pushes the expectation before
    // driving and pops it once the cycle has returned to IDLE.
    task automatic run_cycle(input logic [15:0] ang, input logic a_val, input logic b_val,
                             input int sa, input int early_k, input logic keep_en,
                             output logic [11:0] dc_a, output logic [11:0] dc_b);
        exp_t e;
        int   ups;
        int   dns;
        int   up_res;
        int   dn_res;
        logic err_res;
        logic busy_res;
        bit   stable;
        e.dc_a = model_dc(ang[15:13], ang[12:9], 1'b0);
        e.dc_b = model_dc(ang[15:13], ang[12:9], 1'b1);
        e.up   = (a_val && !b_val) ? 1 : 0;
        e.dn   = (!a_val && b_val) ? 1 : 0;
        if (a_val || b_val) err_cnt_m = (err_cnt_m == 15) ? 15 : err_cnt_m + 1;
        else err_cnt_m = 0;
        e.err = (err_cnt_m >= int'(ERRN)) || (a_val && b_val);
        sb_q.push_back(e);

        en = 1'b1; angle = ang; sample_strb = 1'b0; tlc1h = 1'b0;
        step();
        checks++;
        if (dc !== 12'd0 || busy !== 1'b1)
            begin errors++; $display("FAIL gap_a: dc=%h busy=%b, need dc=000 busy=1", dc, busy); end
        en = keep_en;
        angle = 16'($urandom);
        ups = 0; dns = 0;
        step();
        dc_a = dc;
        stable = 1'b1;
        for (int k = 1; k <= sa; k++) begin
            sample_strb = (k == sa) || (k == early_k);
            tlc1h = (k == sa) ? a_val : ~a_val;
            step();
            ups += int'(cnt_up); dns += int'(cnt_dn);
            if (k < sa && dc !== dc_a) stable = 1'b0;
        end
        sample_strb = 1'b0;
        checks++;
        if (!stable || dc !== 12'd0 || busy !== 1'b1)
            begin errors++; $display("FAIL gap_b: stable=%b dc=%h busy=%b, need 1/000/1", stable, dc, busy); end
        step();
        dc_b = dc;
        stable = 1'b1;
        for (int k = 1; k <= int'(SETTLE) + 1; k++) begin
            sample_strb = (k == int'(SETTLE) + 1);
            tlc1h = b_val;
            step();
            ups += int'(cnt_up); dns += int'(cnt_dn);
            if (k <= int'(SETTLE) && dc !== dc_b) stable = 1'b0;
        end
        sample_strb = 1'b0;
        up_res = int'(cnt_up); dn_res = int'(cnt_dn); err_res = coarse_err; busy_res = busy;
        step();
        ups += int'(cnt_up); dns += int'(cnt_dn);
        checks++;
        if (!stable || busy_res !== 1'b1 || busy !== 1'b0 || dc !== 12'd0)
            begin
                errors++;
                $display("FAIL resolve_idle: stable=%b busy_res=%b busy=%b dc=%h, need 1/1/0/000",
                         stable, busy_res, busy, dc);
            end

        e = sb_q.pop_front();
        checks++;
        if (dc_a !== e.dc_a || dc_b !== e.dc_b)
            begin errors++; $display("FAIL sb_dc: got %h/%h, need %h/%h", dc_a, dc_b, e.dc_a, e.dc_b); end
        checks++;
        if (ups != e.up || dns != e.dn || up_res != e.up || dn_res != e.dn)
            begin
                errors++;
                $display("FAIL sb_pulse: up=%0d dn=%0d (at resolve %0d/%0d), need %0d/%0d",
                         ups, dns, up_res, dn_res, e.up, e.dn);
            end
        checks++;
        if (err_res !== e.err)
            begin errors++; $display("FAIL sb_err: coarse_err=%b, need %b", err_res, e.err); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; angle = 16'd0; sample_strb = 1'b0; tlc1h = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (dc !== 12'd0 || cnt_up !== 1'b0 || cnt_dn !== 1'b0 || coarse_err !== 1'b0 || busy !== 1'b0)
            begin
                errors++;
                $display("FAIL reset: dc=%h up=%b dn=%b err=%b busy=%b, need all 0",
                         dc, cnt_up, cnt_dn, coarse_err, busy);
            end
        err_cnt_m = 0;
    endtask

    task automatic test_decode();
        logic [11:0] da, db;
        for (int o = 0; o < 8; o++) begin
            run_cycle({3'(o), 4'b1010, 9'($urandom)}, 1'b0, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
            checks++;
            if ($countones(da) != 4 || $countones(db) != 4 || da[11:8] !== 4'b0101
                || db[11:8] !== 4'b0101)
                begin errors++; $display("FAIL decode_bits oct%0d: a=%h b=%h, need 4 bits, ref 0101", o, da, db); end
        end
    endtask

    task automatic test_up_down();
        logic [11:0] da, db;
        run_cycle(16'h3a55, 1'b1, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'hc1f0, 1'b0, 1'b1, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'h7777, 1'b0, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'h0123, 1'b0, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        // en was dropped mid-cycle, so the block must stay parked in IDLE.
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || coarse_err !== 1'b0)
            begin errors++; $display("FAIL stop_idle: busy=%b err=%b, need 0/0", busy, coarse_err); end
    endtask

    task automatic test_err_filter();
        logic [11:0] da, db;
        run_cycle(16'h2000, 1'b1, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'h4000, 1'b1, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'h6000, 1'b0, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'h8000, 1'b1, 1'b1, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'ha000, 1'b0, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
    endtask

    task automatic test_settling();
        logic [11:0] da, db;
        // Early strobe carries the opposite tlc1h; accepting it would flip the result.
        run_cycle(16'h5a5a, 1'b1, 1'b0, 45, 5, 1'b0, da, db);
        run_cycle(16'hb3c3, 1'b0, 1'b1, 45, 5, 1'b0, da, db);
    endtask

    task automatic test_back_to_back();
        logic [11:0] da, db;
        run_cycle(16'he0e0, 1'b1, 1'b0, int'(SETTLE) + 1, 0, 1'b1, da, db);
        run_cycle(16'h1e1e, 1'b0, 1'b1, int'(SETTLE) + 1, 0, 1'b1, da, db);
        run_cycle(16'h9999, 1'b0, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
    endtask

    task automatic test_reset_mid();
        logic [11:0] da, db;
        run_cycle(16'h1111, 1'b1, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        run_cycle(16'h2222, 1'b1, 1'b0, int'(SETTLE) + 1, 0, 1'b0, da, db);
        en = 1'b1; angle = 16'h4321;
        step();
        en = 1'b0;
        step();
        for (int k = 1; k <= int'(SETTLE) + 1; k++) begin
            sample_strb = (k == int'(SETTLE) + 1); tlc1h = 1'b1;
            step();
        end
        sample_strb = 1'b0; tlc1h = 1'b0;
        step();
        repeat (4) step();
        checks++;
        if (busy !== 1'b1 || dc === 12'd0)
            begin errors++; $display("FAIL pre_reset_drive_b: busy=%b dc=%h, need 1/nonzero", busy, dc); end
        rst = 1'b1;
        step();
        checks++;
        if (dc !== 12'd0 || busy !== 1'b0 || cnt_up !== 1'b0 || cnt_dn !== 1'b0 || coarse_err !== 1'b0)
            begin
                errors++;
                $display("FAIL reset_mid: dc=%h busy=%b up=%b dn=%b err=%b, need all 0",
                         dc, busy, cnt_up, cnt_dn, coarse_err);
            end
        rst = 1'b0;
        err_cnt_m = 0;
        for (int k = 0; k < int'(SETTLE) + 4; k++) begin
            sample_strb = 1'b1; tlc1h = 1'b1;
            step();
        end
        sample_strb = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt_up !== 1'b0 || cnt_dn !== 1'b0)
            begin errors++; $display("FAIL post_reset_idle: busy=%b up=%b dn=%b, need 0/0/0", busy, cnt_up, cnt_dn); end
        run_cycle(16'h8765, 1'b0, 1'b1, int'(SETTLE) + 1, 0, 1'b0, da, db);
    endtask

    initial begin
        test_reset();
        test_decode();
        test_up_down();
        test_err_filter();
        test_settling();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
